// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: latches a memory-stage request, issues it on a valid/ready bus, returns the read word.
// Latency: write done 2 cycles after request (zero wait), read 2+ cycles; timeout forces DONE at MAX_WAIT+1.
// Backpressure: pipeline held via combinational o_stall while the request is outstanding; bus request held until i_bus_ready.
module dmem_req_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_mask,
   output logic        o_stall,
   output logic [31:0] o_rdata,
   output logic        o_rdata_valid,
   output logic        o_err,
   output logic        o_bus_valid,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_addr,
   output logic        o_bus_we,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_mask,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic        we_q;
   logic [7:0]  wait_cnt;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        req_take;
   logic        cap_rdata;
   logic        timeout;

   // Byte offset is dropped: the bus is word-addressed and the stage shifter handles lanes.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^i_req_addr[1:0];

   assign req_take = (state == IDLE) && (i_req_wen || i_req_ren);

   // Next-state logic; a completion in the final budget cycle wins over timeout.
   always_comb begin
      state_nxt = state;
      cap_rdata = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (i_req_wen || i_req_ren) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (i_bus_ready && we_q) begin
               state_nxt = DONE;
            end else if (i_bus_ready && i_bus_rvalid) begin
               cap_rdata = 1'b1;
               state_nxt = DONE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = DONE;
            end else if (i_bus_ready) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (i_bus_rvalid) begin
               cap_rdata = 1'b1;
               state_nxt = DONE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Request registers keep bus outputs stable for the whole transaction; write wins over read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         we_q    <= 1'b0;
      end else if (req_take) begin
         addr_q  <= i_req_addr[31:2];
         wdata_q <= i_req_wdata;
         mask_q  <= i_req_mask;
         we_q    <= i_req_wen;
      end
   end

   // Cycle budget counter: zeroed on entry to ISSUE, counts every ISSUE/WAIT cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst)                                wait_cnt <= '0;
      else if (req_take)                        wait_cnt <= '0;
      else if (state == ISSUE || state == WAIT) wait_cnt <= wait_cnt + 8'd1;
   end

   // Read word holds until the next read completes; timeout returns zero.
   always_ff @(posedge i_clk) begin
      if (i_rst)          rdata_q <= '0;
      else if (timeout)   rdata_q <= '0;
      else if (cap_rdata) rdata_q <= i_bus_rdata;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst)        err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
   end

   assign o_stall       = !i_rst && (req_take || state == ISSUE || state == WAIT);
   assign o_rdata       = rdata_q;
   assign o_rdata_valid = (state == DONE) && !we_q;
   assign o_err         = err_q;
   assign o_bus_valid   = (state == ISSUE);
   assign o_bus_addr    = {addr_q, 2'b00};
   assign o_bus_we      = we_q;
   assign o_bus_wdata   = wdata_q;
   assign o_bus_mask    = mask_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: directed requests, bus-accept and read-return scoreboards.
// Latency: checks exact cycle positions of stall, bus valid, DONE and timeout.
// Backpressure: bus ready/rvalid driven per cycle from the stimulus sequence.
module tb_dmem_req_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] req_addr;
   logic        req_ren;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic [3:0]  req_mask;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   logic        a_stall, a_rdata_valid, a_err, a_bus_valid, a_bus_we;
   logic [31:0] a_rdata, a_bus_addr, a_bus_wdata;
   logic [3:0]  a_bus_mask;
   logic        b_stall, b_rdata_valid, b_err, b_bus_valid, b_bus_we;
   logic [31:0] b_rdata, b_bus_addr, b_bus_wdata;
   logic [3:0]  b_bus_mask;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] rd_q[$];
   bus_t        exp_bus;
   logic [31:0] exp_rd;
   logic        mon_en;
   int          total = 0;
   int          bad   = 0;

   always #5 i_clk = ~i_clk;

   dmem_req_ctrl #(.MAX_WAIT(15)) u_dut_a (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_addr(req_addr), .i_req_ren(req_ren), .i_req_wen(req_wen),
      .i_req_wdata(req_wdata), .i_req_mask(req_mask),
      .o_stall(a_stall), .o_rdata(a_rdata), .o_rdata_valid(a_rdata_valid), .o_err(a_err),
      .o_bus_valid(a_bus_valid), .i_bus_ready(bus_ready), .o_bus_addr(a_bus_addr),
      .o_bus_we(a_bus_we), .o_bus_wdata(a_bus_wdata), .o_bus_mask(a_bus_mask),
      .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
   );

   dmem_req_ctrl #(.MAX_WAIT(4)) u_dut_b (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_addr(req_addr), .i_req_ren(req_ren), .i_req_wen(req_wen),
      .i_req_wdata(req_wdata), .i_req_mask(req_mask),
      .o_stall(b_stall), .o_rdata(b_rdata), .o_rdata_valid(b_rdata_valid), .o_err(b_err),
      .o_bus_valid(b_bus_valid), .i_bus_ready(bus_ready), .o_bus_addr(b_bus_addr),
      .o_bus_we(b_bus_we), .o_bus_wdata(b_bus_wdata), .o_bus_mask(b_bus_mask),
      .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
   endtask

   task automatic finish_req();
      nxt();
      req_ren    = 1'b0;
      req_wen    = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
   endtask

   // Monitor: every accepted bus request and every read return is matched against the queues.
   always @(negedge i_clk) begin
      if (mon_en && !i_rst) begin
         if (a_bus_valid && bus_ready) begin
            if (bus_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL bus_accept: got unexpected accept addr 0x%08h expected none", a_bus_addr);
            end else begin
               exp_bus = bus_q.pop_front();
               chk("bus_addr",  a_bus_addr,          exp_bus.addr);
               chk("bus_we",    {31'd0, a_bus_we},   {31'd0, exp_bus.we});
               chk("bus_wdata", a_bus_wdata,         exp_bus.wdata);
               chk("bus_mask",  {28'd0, a_bus_mask}, {28'd0, exp_bus.mask});
            end
         end
         if (a_rdata_valid) begin
            if (rd_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rdata_ret: got unexpected read 0x%08h expected none", a_rdata);
            end else begin
               exp_rd = rd_q.pop_front();
               chk("rdata_ret", a_rdata, exp_rd);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; req_addr = '0; req_ren = 1'b0; req_wen = 1'b0;
      req_wdata = '0; req_mask = '0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      bus_rdata = '0; mon_en = 1'b1;

      // Reset values; stall forced low under reset even with a request present
      nxt(); nxt();
      req_ren = 1'b1;
      smp();
      chk("rst_stall",       {31'd0, a_stall},       32'd0);
      chk("rst_bus_valid",   {31'd0, a_bus_valid},   32'd0);
      chk("rst_bus_addr",    a_bus_addr,             32'd0);
      chk("rst_bus_we",      {31'd0, a_bus_we},      32'd0);
      chk("rst_bus_wdata",   a_bus_wdata,            32'd0);
      chk("rst_bus_mask",    {28'd0, a_bus_mask},    32'd0);
      chk("rst_rdata",       a_rdata,                32'd0);
      chk("rst_rdata_valid", {31'd0, a_rdata_valid}, 32'd0);
      chk("rst_err",         {31'd0, a_err},         32'd0);
      nxt();
      i_rst = 1'b0; req_ren = 1'b0;
      smp();
      chk("idle_stall", {31'd0, a_stall}, 32'd0);

      // Zero-wait write
      nxt();
      req_wen = 1'b1; req_addr = 32'h0000_1003; req_wdata = 32'hAABB_CCDD;
      req_mask = 4'b1000; bus_ready = 1'b1;
      bus_q.push_back('{addr: 32'h0000_1000, we: 1'b1, wdata: 32'hAABB_CCDD, mask: 4'b1000});
      smp();
      chk("wr_c0_stall", {31'd0, a_stall},     32'd1);
      chk("wr_c0_valid", {31'd0, a_bus_valid}, 32'd0);
      nxt(); smp();
      chk("wr_c1_stall", {31'd0, a_stall},     32'd1);
      chk("wr_c1_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); smp();
      chk("wr_c2_stall",  {31'd0, a_stall},       32'd0);
      chk("wr_c2_valid",  {31'd0, a_bus_valid},   32'd0);
      chk("wr_c2_rvalid", {31'd0, a_rdata_valid}, 32'd0);
      finish_req();

      // Read with wait states: ready at cycle 3, rvalid at cycle 5
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_2000; req_wdata = 32'd0; req_mask = 4'hF;
      bus_q.push_back('{addr: 32'h0000_2000, we: 1'b0, wdata: 32'd0, mask: 4'hF});
      rd_q.push_back(32'h1234_5678);
      smp();
      chk("rd_c0_stall", {31'd0, a_stall}, 32'd1);
      nxt(); smp();
      chk("rd_c1_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); smp();
      chk("rd_c2_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); bus_ready = 1'b1; smp();
      chk("rd_c3_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); bus_ready = 1'b0; smp();
      chk("rd_c4_valid", {31'd0, a_bus_valid}, 32'd0);
      chk("rd_c4_stall", {31'd0, a_stall},     32'd1);
      nxt(); bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; smp();
      chk("rd_c5_stall",  {31'd0, a_stall},       32'd1);
      chk("rd_c5_rvalid", {31'd0, a_rdata_valid}, 32'd0);
      nxt(); bus_rvalid = 1'b0; smp();
      chk("rd_c6_stall",  {31'd0, a_stall},       32'd0);
      chk("rd_c6_rvalid", {31'd0, a_rdata_valid}, 32'd1);
      chk("rd_c6_rdata",  a_rdata,                32'h1234_5678);
      finish_req();

      // Ready and rvalid in the same cycle
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_3008; req_wdata = 32'd0; req_mask = 4'hF;
      bus_q.push_back('{addr: 32'h0000_3008, we: 1'b0, wdata: 32'd0, mask: 4'hF});
      rd_q.push_back(32'hDEAD_BEEF);
      smp();
      nxt(); bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; smp();
      chk("cmb_c1_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); bus_ready = 1'b0; bus_rvalid = 1'b0; smp();
      chk("cmb_c2_stall",  {31'd0, a_stall},       32'd0);
      chk("cmb_c2_rvalid", {31'd0, a_rdata_valid}, 32'd1);
      chk("cmb_c2_valid",  {31'd0, a_bus_valid},   32'd0);
      finish_req();

      // Write has priority when both enables are high
      nxt();
      req_ren = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_4000;
      req_wdata = 32'h0102_0304; req_mask = 4'hF; bus_ready = 1'b1;
      bus_q.push_back('{addr: 32'h0000_4000, we: 1'b1, wdata: 32'h0102_0304, mask: 4'hF});
      smp();
      nxt(); smp();
      chk("pri_c1_we", {31'd0, a_bus_we}, 32'd1);
      nxt(); smp();
      chk("pri_c2_rvalid", {31'd0, a_rdata_valid}, 32'd0);
      chk("pri_c2_rdata",  a_rdata,                32'hDEAD_BEEF);
      chk("pri_c2_stall",  {31'd0, a_stall},       32'd0);
      finish_req();

      // Write with empty mask, then a read presented in the IDLE cycle after DONE
      nxt();
      req_wen = 1'b1; req_addr = 32'h0000_5004; req_wdata = 32'h0BAD_CAFE;
      req_mask = 4'b0000; bus_ready = 1'b1;
      bus_q.push_back('{addr: 32'h0000_5004, we: 1'b1, wdata: 32'h0BAD_CAFE, mask: 4'b0000});
      smp();
      nxt(); smp();
      chk("b2b_c1_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); smp();
      chk("b2b_c2_stall", {31'd0, a_stall}, 32'd0);
      nxt();
      req_wen = 1'b0; req_ren = 1'b1; req_addr = 32'h0000_500C;
      req_wdata = 32'd0; req_mask = 4'hF;
      bus_q.push_back('{addr: 32'h0000_500C, we: 1'b0, wdata: 32'd0, mask: 4'hF});
      rd_q.push_back(32'hCAFE_F00D);
      smp();
      chk("b2b_c3_stall", {31'd0, a_stall},     32'd1);
      chk("b2b_c3_valid", {31'd0, a_bus_valid}, 32'd0);
      nxt(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D; smp();
      chk("b2b_c4_valid", {31'd0, a_bus_valid}, 32'd1);
      nxt(); bus_rvalid = 1'b0; smp();
      chk("b2b_c5_rvalid", {31'd0, a_rdata_valid}, 32'd1);
      chk("b2b_c5_stall",  {31'd0, a_stall},       32'd0);
      finish_req();

      // Reset while waiting for read data; late rvalid must be ignored
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_7000; req_wdata = 32'd0; req_mask = 4'hF;
      bus_q.push_back('{addr: 32'h0000_7000, we: 1'b0, wdata: 32'd0, mask: 4'hF});
      smp();
      nxt(); bus_ready = 1'b1; smp();
      nxt(); bus_ready = 1'b0; smp();
      chk("mrst_c2_stall", {31'd0, a_stall},     32'd1);
      chk("mrst_c2_valid", {31'd0, a_bus_valid}, 32'd0);
      nxt(); i_rst = 1'b1; req_ren = 1'b0; smp();
      chk("mrst_c3_stall", {31'd0, a_stall}, 32'd0);
      nxt(); i_rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA; smp();
      chk("mrst_c4_stall", {31'd0, a_stall},     32'd0);
      chk("mrst_c4_valid", {31'd0, a_bus_valid}, 32'd0);
      chk("mrst_c4_rdata", a_rdata,              32'd0);
      nxt(); bus_rvalid = 1'b0; smp();
      chk("mrst_c5_rdata",  a_rdata,                32'd0);
      chk("mrst_c5_rvalid", {31'd0, a_rdata_valid}, 32'd0);
      chk("mrst_c5_err",    {31'd0, a_err},         32'd0);

      chk("bus_q_empty", bus_q.size(), 32'd0);
      chk("rd_q_empty",  rd_q.size(),  32'd0);

      // Timeout on the MAX_WAIT=4 instance
      mon_en = 1'b0;
      nxt(); i_rst = 1'b1;
      nxt(); i_rst = 1'b0; smp();
      chk("to_rst_err", {31'd0, b_err}, 32'd0);
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_6000; req_mask = 4'hF; smp();
      nxt(); bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222; smp();
      nxt(); bus_ready = 1'b0; bus_rvalid = 1'b0; smp();
      chk("to_pre_rdata", b_rdata, 32'h1111_2222);
      finish_req();
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_6100; smp();
      chk("to_c0_stall", {31'd0, b_stall}, 32'd1);
      nxt(); smp();
      chk("to_c1_valid", {31'd0, b_bus_valid}, 32'd1);
      nxt(); nxt(); nxt(); smp();
      chk("to_c4_err",   {31'd0, b_err},       32'd0);
      chk("to_c4_stall", {31'd0, b_stall},     32'd1);
      chk("to_c4_valid", {31'd0, b_bus_valid}, 32'd1);
      nxt(); smp();
      chk("to_c5_err",    {31'd0, b_err},         32'd1);
      chk("to_c5_rdata",  b_rdata,                32'd0);
      chk("to_c5_stall",  {31'd0, b_stall},       32'd0);
      chk("to_c5_valid",  {31'd0, b_bus_valid},   32'd0);
      chk("to_c5_rvalid", {31'd0, b_rdata_valid}, 32'd1);
      finish_req();
      nxt();
      req_ren = 1'b1; req_addr = 32'h0000_6200; smp();
      nxt(); bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h3333_4444; smp();
      nxt(); bus_ready = 1'b0; bus_rvalid = 1'b0; smp();
      chk("to_post_rdata",  b_rdata,                32'h3333_4444);
      chk("to_post_rvalid", {31'd0, b_rdata_valid}, 32'd1);
      chk("to_post_err",    {31'd0, b_err},         32'd1);
      finish_req();
      smp();
      chk("to_sticky_err", {31'd0, b_err}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_req_ctrl.md
# dmem_req_ctrl

Data-memory request controller sitting directly downstream of the pipeline's memory stage. It accepts the stage's single-cycle read/write request (address, enables, write data, byte mask), issues it to a variable-latency data-memory bus with a valid/ready handshake, and holds the pipeline stalled until the transaction completes. It returns word-aligned read data, which the memory stage's output shifter consumes, and it flags a sticky error when the bus fails to respond within a bounded number of cycles.

## Interface
- MAX_WAIT, 15: maximum cycles spent in ISSUE+WAIT before timeout; legal range 1..255.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_addr  in  32  byte address from the memory stage.
- i_req_ren  in  1  read request.
- i_req_wen  in  1  write request; has priority over i_req_ren.
- i_req_wdata  in  32  write data, already lane-aligned.
- i_req_mask  in  4  byte-lane enables.
- o_stall  out  1  combinational pipeline freeze.
- o_rdata  out  32  registered read word.
- o_rdata_valid  out  1  read completed; high in DONE only.
- o_err  out  1  sticky timeout flag.
- o_bus_valid  out  1  bus request valid.
- i_bus_ready  in  1  bus accepts the request.
- o_bus_addr  out  32  {addr[31:2],2'b00}.
- o_bus_we  out  1  1 = write.
- o_bus_wdata  out  32  write data.
- o_bus_mask  out  4  byte enables.
- i_bus_rvalid  in  1  read data valid.
- i_bus_rdata  in  32  read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On i_req_wen or i_req_ren, latch addr/wdata/mask/we (we = i_req_wen) into request registers and go to ISSUE.
  - i_bus_rvalid is ignored in IDLE.
- **ISSUE**
  - o_bus_valid=1; bus outputs driven from the request registers and stable until accepted.
  - i_bus_ready with we=1: go to DONE.
  - i_bus_ready with we=0 and i_bus_rvalid=1 in the same cycle: capture i_bus_rdata, go to DONE.
  - i_bus_ready with we=0 and no rvalid: go to WAIT.
- **WAIT**
  - o_bus_valid=0.
  - On i_bus_rvalid: capture i_bus_rdata into o_rdata, go to DONE.
- **DONE**
  - One cycle; o_stall=0, so the pipeline advances at the end of this cycle.
  - Request inputs are ignored (they still hold the old, completed request); always return to IDLE.
  - o_rdata_valid = !we_reg.
- **Timeout**
  - Counter cleared on entry to ISSUE; increments each cycle in ISSUE/WAIT.
  - If the counter equals MAX_WAIT-1 and no completion occurs that cycle: set o_err, load o_rdata=0, go to DONE.
  - o_err stays set until reset.
- o_stall = (IDLE & (i_req_ren|i_req_wen)) | ISSUE | WAIT; forced 0 while i_rst is high.
- o_rdata holds its value until the next read completes; write completion does not change it.
- A write with mask 4'b0000 is still issued on the bus.
- Reset mid-transaction:
  - State returns to IDLE, o_bus_valid drops next edge, counter is cleared.
  - A late rvalid after reset is ignored.

## Timing
- Reset values: o_bus_valid=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_bus_mask=0, o_rdata=0, o_rdata_valid=0, o_err=0, state=IDLE.
- Cycle numbering below has the request appear at cycle 0.
- Write, ready immediately: stall in cycles 0–1, DONE in cycle 2.
- Read, ready at cycle 1 and rvalid at cycle 2: stall in cycles 0–2, DONE with valid data in cycle 3.
- Read, ready and rvalid both at cycle 1: DONE in cycle 2.
- Bus wait states add one cycle each; the worst case is DONE at cycle MAX_WAIT+1.
- Back-to-back requests: the next request is seen in the IDLE cycle after DONE, giving a minimum of 3 cycles per write.

## Test plan
- **Zero-wait write:** addr 0x1003, wdata 0xAABBCCDD, mask 4'b1000, ready held high.
  - o_bus_addr = 0x1000, o_bus_we = 1, o_bus_valid high in cycle 1 only.
  - o_stall high in cycles 0–1; DONE in cycle 2 with o_rdata_valid = 0.
- **Read with wait states:** ready at cycle 3, rvalid at cycle 5 with data 0x12345678.
  - o_bus_valid high in cycles 1–3.
  - o_rdata = 0x12345678 with o_rdata_valid = 1 in cycle 6; stall low in cycle 6.
- **Combined accept and response:** read where ready and rvalid are both high in cycle 1, data 0xDEADBEEF.
  - DONE in cycle 2; WAIT is never entered.
- **Timeout:** MAX_WAIT = 4, ready never asserted.
  - o_err rises at the DONE edge (cycle 5), with o_rdata = 0.
  - A subsequent normal read completes and o_err remains 1.
- **Enable priority:** ren = 1 and wen = 1 together.
  - o_bus_we = 1 and o_rdata is unchanged.
  - Then issue a write followed immediately by a read: the read is issued in the cycle after IDLE (no loss, no duplication).
- **Reset mid-read:** assert i_rst during WAIT.
  - Next cycle: IDLE, o_stall = 0, o_bus_valid = 0.
  - A stray rvalid (data 0x5555AAAA) is ignored and o_rdata stays 0.
